bicubic_phase_sched: RTL
========================

# bicubic_phase_sched

Phase scheduler and result collector for the horizontal bicubic x2 weight datapath. For each output pixel of a line it walks a fixed-point source position and issues the fractional phase and kernel parameter to the four-tap weight pipelines. It captures the returned tap weights together with the integer source index, and presents them to the pixel interpolator through a valid/ready FIFO. It sits between the line/frame control and the weight kernels, and uses credit counting so that the non-stallable kernel pipelines never overflow.

## Interface
Parameters:
- KERNEL_LAT, 4: cycles from `k_valid` to the matching `k_result`; fixed and non-stallable.
- FIFO_DEPTH, 8: output FIFO entries; must be ≥ 2 and a power of 2.
- COORD_W, 12: width of the integer source/output coordinate.

Ports:
- clk in 1: single clock; all logic on the rising edge.
- rst_n in 1: asynchronous, active-low reset.
- start in 1: one-cycle pulse that begins a line; ignored while `busy`.
- out_width in COORD_W: output pixels per line; sampled on `start`.
- step in 10: source increment per output pixel, Q2.8 (0x080 = x2); sampled on `start`.
- bi_a in 9: kernel parameter a, Q1.8; sampled on `start`.
- busy out 1: high from the cycle after `start` until `line_done`.
- k_valid out 1: issue strobe to the weight kernels.
- k_xblend out 9: phase fraction, Q1.8, range 0..255 (bit 8 always 0).
- k_bi_a out 9: latched `bi_a`.
- k_result in 68: {w3,w2,w1,w0}, 17 bits each; valid KERNEL_LAT cycles after `k_valid`.
- out_valid out 1; out_ready in 1: output handshake.
- out_weights out 68; out_src_idx out COORD_W; out_last out 1: FIFO head.
- line_done out 1: one-cycle pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start` with `out_width` ≠ 0. The block latches width, step and a, and clears `pos` (Q(COORD_W).8) and `cnt`.
  - `start` with `out_width` = 0 → no issues; `line_done` pulses next cycle; FSM stays in IDLE.
- RUN behaviour:
  - Issue whenever `credit` > 0.
  - On issue: `k_xblend` = {1'b0,pos[7:0]}; `pos` += `step`; `cnt`++.
  - On issue, push {pos[COORD_W+7:8], cnt==width-1} into a KERNEL_LAT-deep tag shift register alongside `k_valid`.
  - After the issue with `cnt` == width-1 → DRAIN.
- DRAIN→IDLE when the FIFO is empty and no tags are in flight. `line_done` pulses in the cycle the FIFO pops its last entry (`out_last` accepted).
- Credit counter:
  - Reset value is FIFO_DEPTH.
  - Decrements on issue; increments on FIFO pop.
  - Issue and pop in the same cycle leave it unchanged.
  - It never exceeds FIFO_DEPTH and never goes below 0.
- The FIFO write occurs when the delayed `k_valid` tag emerges. It stores `k_result`, the index and the last flag. Writing into a full FIFO is impossible by construction; the bench asserts this.
- Arithmetic: the `pos` adder is unsigned and wraps modulo 2^(COORD_W+8) without a flag.
- Outputs are registered. The `k_*` outputs hold their last value when `k_valid` = 0.

## Timing
- Reset values:
  - `busy`, `k_valid`, `out_valid`, `out_last` and `line_done` = 0.
  - `k_xblend`, `k_bi_a`, `out_weights` and `out_src_idx` = 0.
  - `credit` = FIFO_DEPTH; FSM = IDLE.
- `start` sampled at edge 0 → `busy` and the first `k_valid` in cycle 1.
- Issue in cycle t → FIFO write at the end of cycle t+KERNEL_LAT → `out_valid` in cycle t+KERNEL_LAT+1. First output therefore appears in cycle KERNEL_LAT+2.
- Throughput: 1 pixel/cycle when `out_ready` is held high.
- `out_valid` holds, and the head is stable, until `out_ready` is sampled high.
- Reset asserted mid-line: everything clears immediately. In-flight kernel results are discarded because the tag register is cleared.

## Configuration
- BICUBIC_SCHED_ABORT_EN:
  - Defined: adds input `abort` (1 bit).
  - `abort` in RUN or DRAIN stops issuing, flushes the tag register and FIFO, and restores `credit` = FIFO_DEPTH. FSM → IDLE next cycle, with `line_done` pulsed and `out_last` never emitted.
  - `abort` in IDLE is ignored; `abort` together with `start` gives `abort` priority.
  - Undefined: no `abort` port and no flush path; behaviour otherwise identical.

## Test plan
- Basic walk: width=4, step=0x080, a=0x180, `out_ready`=1 → `k_xblend` 0,128,0,128; `out_src_idx` 0,0,1,1; `out_last` on the 4th output only; `line_done` in cycle KERNEL_LAT+5.
- Backpressure: width=20, step=0x080, `out_ready`=0 for 30 cycles → exactly 8 `k_valid` pulses, then stall. After `out_ready`=1, all 20 outputs arrive in order with no loss or duplication.
- Zero width: `start` with width=0 → no `k_valid`, `busy` stays 0, `line_done` pulses in cycle 1.
- Simultaneous issue/pop with alternating `out_ready` → credit never exceeds 8; FIFO overflow assertion never fires; indices correct.
- Reset mid-line after 5 issues → all outputs return to 0 immediately. A new `start` then yields index 0 and phase 0 first.
- With BICUBIC_SCHED_ABORT_EN: `abort` at the 3rd issue of a width=10 line → no further `k_valid`, `out_valid`=0 next cycle, `line_done` pulse, `credit`=8.

Source files
------------

// File: rtl/bicubic_phase_sched.sv
// Phase walker and credit-guarded result FIFO feeding the bicubic x2 weight kernels.
// Optional abort/flush path is compiled in when BICUBIC_SCHED_ABORT_EN is defined.
module bicubic_phase_sched #(
  parameter int KERNEL_LAT = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int COORD_W    = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [COORD_W-1:0]           out_width,
  input  logic [9:0]                   step,
  input  logic [8:0]                   bi_a,
`ifdef BICUBIC_SCHED_ABORT_EN
  input  logic                         abort,
`endif
  output logic                         busy,
  output logic                         k_valid,
  output logic [8:0]                   k_xblend,
  output logic [8:0]                   k_bi_a,
  input  logic [67:0]                  k_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [67:0]                  out_weights,
  output logic [COORD_W-1:0]           out_src_idx,
  output logic                         out_last,
  output logic                         line_done,
  output logic [1:0]                   dbg_state_o,
  output logic [$clog2(FIFO_DEPTH):0]  dbg_credit_o
);

  localparam int PW  = COORD_W + 8;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CRW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] width_q, width_d;
  logic [9:0]         step_q, step_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [COORD_W-1:0] cnt_q, cnt_d;
  logic [CRW-1:0]     credit_q, credit_d;
  logic               k_valid_q, k_valid_d;
  logic [8:0]         k_xblend_q, k_xblend_d;
  logic [8:0]         k_bi_a_q, k_bi_a_d;
  logic [COORD_W-1:0] k_idx_q, k_idx_d;
  logic               k_last_q, k_last_d;
  logic               done_q, done_d;
  logic               issue, flush, abort_w;

  logic               tag_v_q    [KERNEL_LAT];
  logic [COORD_W-1:0] tag_idx_q  [KERNEL_LAT];
  logic               tag_last_q [KERNEL_LAT];

  logic [67:0]        mem_w_q    [FIFO_DEPTH];
  logic [COORD_W-1:0] mem_idx_q  [FIFO_DEPTH];
  logic               mem_last_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CRW-1:0]     count_q, count_d;
  logic               out_valid_q;
  logic               fifo_wr, pop, head_last;

`ifdef BICUBIC_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Output handshake: an entry transfers in every cycle where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_valid and the head stay unchanged.
  assign pop       = out_valid_q && out_ready;
  assign head_last = mem_last_q[rd_ptr_q];
  assign fifo_wr   = tag_v_q[KERNEL_LAT-1] && !flush;

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    step_d     = step_q;
    pos_d      = pos_q;
    cnt_d      = cnt_q;
    k_valid_d  = 1'b0;
    k_xblend_d = k_xblend_q;
    k_bi_a_d   = k_bi_a_q;
    k_idx_d    = k_idx_q;
    k_last_d   = k_last_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort_w) begin
          if (out_width == '0) begin
            done_d = 1'b1;
          end else begin
            // First pixel issues on the accepting edge so k_valid rises with busy.
            width_d    = out_width;
            step_d     = step;
            k_bi_a_d   = bi_a;
            issue      = 1'b1;
            k_valid_d  = 1'b1;
            k_xblend_d = 9'd0;
            k_idx_d    = '0;
            k_last_d   = (out_width == COORD_W'(1));
            pos_d      = PW'(step);
            cnt_d      = COORD_W'(1);
            state_d    = (out_width == COORD_W'(1)) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort_w) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (credit_q != '0) begin
          issue      = 1'b1;
          k_valid_d  = 1'b1;
          k_xblend_d = {1'b0, pos_q[7:0]};
          k_idx_d    = pos_q[PW-1:8];
          k_last_d   = (cnt_q == width_q - COORD_W'(1));
          pos_d      = pos_q + PW'(step_q);
          cnt_d      = cnt_q + COORD_W'(1);
          if (cnt_q == width_q - COORD_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_w) begin
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (pop && head_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    count_d  = count_q;
    if (flush) begin
      credit_d = CRW'(FIFO_DEPTH);
      count_d  = '0;
    end else begin
      case ({issue, pop})
        2'b10:   credit_d = credit_q - CRW'(1);
        2'b01:   credit_d = credit_q + CRW'(1);
        default: credit_d = credit_q;
      endcase
      case ({fifo_wr, pop})
        2'b10:   count_d = count_q + CRW'(1);
        2'b01:   count_d = count_q - CRW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      width_q    <= '0;
      step_q     <= '0;
      pos_q      <= '0;
      cnt_q      <= '0;
      credit_q   <= CRW'(FIFO_DEPTH);
      k_valid_q  <= 1'b0;
      k_xblend_q <= '0;
      k_bi_a_q   <= '0;
      k_idx_q    <= '0;
      k_last_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      step_q     <= step_d;
      pos_q      <= pos_d;
      cnt_q      <= cnt_d;
      credit_q   <= credit_d;
      k_valid_q  <= k_valid_d;
      k_xblend_q <= k_xblend_d;
      k_bi_a_q   <= k_bi_a_d;
      k_idx_q    <= k_idx_d;
      k_last_q   <= k_last_d;
      done_q     <= done_d;
    end
  end

  // Tag stage i holds the issue from i+1 cycles ago; the last stage lines up with k_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KERNEL_LAT; i++) begin
        tag_v_q[i]    <= 1'b0;
        tag_idx_q[i]  <= '0;
        tag_last_q[i] <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < KERNEL_LAT; i++) tag_v_q[i] <= 1'b0;
    end else begin
      tag_v_q[0]    <= k_valid_q;
      tag_idx_q[0]  <= k_idx_q;
      tag_last_q[0] <= k_last_q;
      for (int i = 1; i < KERNEL_LAT; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_idx_q[i]  <= tag_idx_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_w_q[i]    <= '0;
        mem_idx_q[i]  <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (fifo_wr) begin
          mem_w_q[wr_ptr_q]    <= k_result;
          mem_idx_q[wr_ptr_q]  <= tag_idx_q[KERNEL_LAT-1];
          mem_last_q[wr_ptr_q] <= tag_last_q[KERNEL_LAT-1];
          wr_ptr_q             <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign k_valid      = k_valid_q;
  assign k_xblend     = k_xblend_q;
  assign k_bi_a       = k_bi_a_q;
  assign out_valid    = out_valid_q;
  assign out_weights  = mem_w_q[rd_ptr_q];
  assign out_src_idx  = mem_idx_q[rd_ptr_q];
  assign out_last     = mem_last_q[rd_ptr_q];
  // End of line is the accepted last entry itself; zero-width and abort ends come from done_q.
  assign line_done    = done_q || (pop && head_last && !abort_w);
  assign dbg_state_o  = state_q;
  assign dbg_credit_o = credit_q;

endmodule
